// File: rtl/sum_deserializer.sv
// sum_deserializer: collects LSB-first serial adder sum bits into a held parallel word
// Ports:
//   CLK, rst        clock and synchronous active-high reset
//   start           frame begin strobe
//   bit_valid, S    qualified serial sum bit
//   COUT            final carry, taken with the last bit
//   out_ready       downstream accepts the held word
//   sum, carry_out  assembled word and carry, held while out_valid
//   out_valid       word held in HOLD
//   busy            frame in progress
//   err             one-cycle pulse on a start that collides with a frame or held word
//   sum_par         even parity of {carry_out,sum}, only when SUM_PARITY_EN is defined
module sum_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             S,
    input  logic             COUT,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid,
    output logic             busy,
`ifdef SUM_PARITY_EN
    output logic             sum_par,
`endif
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic last, take_bit, begin_frame, err_nxt;
    assign last      = cnt == CW'(WIDTH - 1);
    assign busy      = state == COLLECT;
    assign out_valid = state == HOLD;
    always_comb begin
        take_bit    = busy && !start && bit_valid;
        // a start in COLLECT restarts the frame; in HOLD it only begins a frame if the word retires
        begin_frame = start && (state != HOLD || out_ready);
        err_nxt     = start && (busy || (out_valid && !out_ready));
        state_nxt   = (state == IDLE) ? (start ? COLLECT : IDLE) :
                      busy            ? ((take_bit && last) ? HOLD : COLLECT) :
                                        (out_ready ? (start ? COLLECT : IDLE) : HOLD);
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            if (begin_frame) begin
                cnt <= '0;
                sum <= '0;
            end else if (take_bit) begin
                sum[cnt] <= S;
                if (last) carry_out <= COUT;
                else cnt <= cnt + CW'(1);
            end
        end
    end
`ifdef SUM_PARITY_EN
    // the slot being written is still zero, so folding S into the old word gives the new parity
    always_ff @(posedge CLK) begin
        if (rst) sum_par <= 1'b0;
        else if (take_bit && last) sum_par <= ^{COUT, S, sum};
        else if (out_valid && out_ready) sum_par <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_sum_deserializer.sv
module tb_sum_deserializer;
    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       S = 1'b0;
    logic       COUT = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       carry_out;
    logic       out_valid;
    logic       busy;
    logic       err;
    logic       sum_par;
    int checks = 0;
    int failures = 0;

    sum_deserializer #(.WIDTH(8)) dut (
        .CLK(CLK), .rst(rst), .start(start), .bit_valid(bit_valid), .S(S), .COUT(COUT),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .out_valid(out_valid),
        .busy(busy),
`ifdef SUM_PARITY_EN
        .sum_par(sum_par),
`endif
        .err(err)
    );
`ifndef SUM_PARITY_EN
    assign sum_par = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic s, input logic c);
        bit_valid = 1'b1;
        S = s;
        COUT = c;
        tick();
        bit_valid = 1'b0;
        COUT = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic c);
        for (int i = 0; i < 8; i++) send_bit(w[i], i == 7 ? c : 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'h0D;
        tick();
        tick();
        check("rst_sum", sum, 0);
        check("rst_carry", carry_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_par", sum_par, 0);
        rst = 1'b0;
        send_bit(1'b1, 1'b1);
        check("idle_bit_busy", busy, 0);
        check("idle_bit_err", err, 0);
        // frame 0x0D with carry, consecutive bits
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        for (int i = 0; i < 7; i++) send_bit(pat[i], 1'b0);
        check("pre_last_valid", out_valid, 0);
        send_bit(pat[7], 1'b1);
        check("f1_valid", out_valid, 1);
        check("f1_sum", sum, 8'h0D);
        check("f1_carry", carry_out, 1);
        check("f1_busy", busy, 0);
`ifdef SUM_PARITY_EN
        check("f1_par", sum_par, 0);
`endif
        send_bit(1'b1, 1'b0);
        check("hold_bit_ignored", sum, 8'h0D);
        // held word with a colliding start on the second cycle
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_start_err", err, 1);
        check("hold_start_sum", sum, 8'h0D);
        check("hold_start_valid", out_valid, 1);
        tick();
        check("hold_err_pulse", err, 0);
        tick();
        tick();
        check("hold_sum", sum, 8'h0D);
        check("hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_valid", out_valid, 0);
        check("retire_busy", busy, 0);
        // same frame with gaps, 15 COLLECT cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bit_valid = (i % 2) == 0;
            S = pat[i / 2];
            COUT = i == 14;
            tick();
            if (i < 14) check("gap_busy", busy, 1);
        end
        bit_valid = 1'b0;
        COUT = 1'b0;
        check("gap_valid", out_valid, 1);
        check("gap_sum", sum, 8'h0D);
        check("gap_carry", carry_out, 1);
        // retire and start in the same cycle
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", out_valid, 0);
        check("b2b_err", err, 0);
        send_word(8'hFF, 1'b0);
        check("ff_sum", sum, 8'hFF);
        check("ff_carry", carry_out, 0);
        check("ff_valid", out_valid, 1);
`ifdef SUM_PARITY_EN
        check("ff_par", sum_par, 0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // abort after 3 bits, restart with a bit that must be discarded
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        start = 1'b1;
        send_bit(1'b1, 1'b0);
        start = 1'b0;
        check("abort_err", err, 1);
        check("abort_busy", busy, 1);
        send_bit(1'b1, 1'b0);
        check("abort_err_pulse", err, 0);
        pat = 8'hA5;
        for (int i = 1; i < 8; i++) send_bit(pat[i], i == 7);
        check("a5_sum", sum, 8'hA5);
        check("a5_carry", carry_out, 1);
        check("a5_valid", out_valid, 1);
`ifdef SUM_PARITY_EN
        check("a5_par", sum_par, 1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // reset mid-frame wins over all other inputs
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        start = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_sum", sum, 0);
        check("mid_rst_carry", carry_out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_par", sum_par, 0);
        rst = 1'b0;
        tick();
        check("post_rst_err", err, 0);
        check("post_rst_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
